// File: rtl/capture_pkg.sv
// Shared types and default parameters for the multi-channel capture path.
// Imported by the capture controller and its register slice.
package capture_pkg;

  typedef enum logic {
    CAP_IDLE  = 1'b0,
    CAP_ARMED = 1'b1
  } cap_state_t;

  localparam int CAP_DATA_W    = 7;
  localparam int CAP_CH        = 4;
  localparam int CAP_TIMEOUT   = 15;
  localparam int CAP_OVERWRITE = 0;

endpackage

// File: rtl/capture_register.sv
// One channel's payload register.
// Loads on enable and clears on async reset.
module capture_register #(
  parameter int DATA_W = 7
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/multi_channel_capture_controller.sv
// Request/confirm capture of a tagged word into one of CH channel registers.
// Adds per-channel valid flags, overwrite protection, timeout and clear.
module multi_channel_capture_controller
  import capture_pkg::*;
#(
  parameter int DATA_W    = CAP_DATA_W,
  parameter int CH        = CAP_CH,
  parameter int SEL_W     = $clog2(CH),
  parameter int TIMEOUT   = CAP_TIMEOUT,
  parameter int OVERWRITE = CAP_OVERWRITE
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    request,
  input  logic                    confirm,
  input  logic [CH-1:0]           clear_mask,
  input  logic [DATA_W+SEL_W-1:0] inputData,
  output logic [CH*DATA_W-1:0]    dataOut,
  output logic [CH-1:0]           valid,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic                    timeout
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLast = TW'(TIMEOUT - 1);
  localparam logic [SEL_W:0] ChLim = (SEL_W + 1)'(CH);

  cap_state_t state;
  logic [TW-1:0] timer;
  logic [DATA_W+SEL_W-1:0] holdReg;

  logic [SEL_W-1:0] inCh;
  logic [SEL_W-1:0] holdCh;
  logic [DATA_W-1:0] holdPay;
  logic inBad;
  logic [CH-1:0] hit;
  logic clash;
  logic commit;
  logic [CH-1:0] wrMask;

  assign inCh    = inputData[SEL_W-1:0];
  assign holdCh  = holdReg[SEL_W-1:0];
  assign holdPay = holdReg[DATA_W+SEL_W-1:SEL_W];
  assign inBad   = {1'b0, inCh} >= ChLim;

  always_comb begin
    hit = '0;
    for (int k = 0; k < CH; k++) begin
      hit[k] = (holdCh == SEL_W'(k));
    end
  end

  // A confirm into an occupied channel is refused unless overwrite is on
  assign clash  = |(hit & valid);
  assign commit = (state == CAP_ARMED) && confirm &&
                  ((OVERWRITE != 0) || !clash);
  assign wrMask = commit ? hit : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= CAP_IDLE;
      timer   <= '0;
      holdReg <= '0;
      valid   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      timeout <= 1'b0;
    end else begin
      done    <= 1'b0;
      err     <= 1'b0;
      timeout <= 1'b0;
      valid   <= (valid & ~clear_mask) | wrMask;
      case (state)
        CAP_IDLE: begin
          if (request) begin
            if (inBad) begin
              err <= 1'b1;
            end else begin
              holdReg <= inputData;
              timer   <= '0;
              state   <= CAP_ARMED;
              busy    <= 1'b1;
            end
          end
        end
        CAP_ARMED: begin
          if (confirm) begin
            state <= CAP_IDLE;
            busy  <= 1'b0;
            done  <= commit;
            err   <= !commit;
          end else if (request) begin
            if (inBad) begin
              err   <= 1'b1;
              state <= CAP_IDLE;
              busy  <= 1'b0;
            end else begin
              holdReg <= inputData;
              timer   <= '0;
            end
          end else if (timer == TLast) begin
            timeout <= 1'b1;
            state   <= CAP_IDLE;
            busy    <= 1'b0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          state <= CAP_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_reg
    capture_register #(
      .DATA_W(DATA_W)
    ) u_reg (
      .clock  (clock),
      .reset_n(reset_n),
      .en     (wrMask[k]),
      .d      (holdPay),
      .q      (dataOut[k*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_multi_channel_capture_controller.sv
// Scoreboard bench: two controllers share stimulus, each checked every
// cycle against a deadline-based model of channel memory and flags.
module tb_multi_channel_capture_controller;

  typedef logic [35:0] exp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic request = 1'b0;
  logic confirm = 1'b0;
  logic [3:0] clrMask = '0;
  logic [8:0] inputData = '0;

  logic [20:0] doA;
  logic [2:0] vA;
  logic busyA, doneA, errA, toA;
  logic [27:0] doB;
  logic [3:0] vB;
  logic busyB, doneB, errB, toB;

  int checks = 0;
  int errors = 0;
  int edgeN = 0;

  exp_t qA[$];
  exp_t qB[$];

  // model state, index 0 = A (CH 3, no overwrite), 1 = B (CH 4, overwrite)
  int chN[2] = '{3, 4};
  int owN[2] = '{0, 1};
  int toN[2] = '{5, 3};
  bit armed[2];
  int hch[2];
  logic [6:0] hpay[2];
  int dl[2];
  logic [6:0] mem[2][4];
  logic [3:0] vm[2];

  always #5 clock = ~clock;

  multi_channel_capture_controller #(
    .DATA_W(7), .CH(3), .TIMEOUT(5), .OVERWRITE(0)
  ) dutA (
    .clock(clock), .reset_n(reset_n),
    .request(request), .confirm(confirm),
    .clear_mask(clrMask[2:0]), .inputData(inputData),
    .dataOut(doA), .valid(vA), .busy(busyA),
    .done(doneA), .err(errA), .timeout(toA)
  );

  multi_channel_capture_controller #(
    .DATA_W(7), .CH(4), .TIMEOUT(3), .OVERWRITE(1)
  ) dutB (
    .clock(clock), .reset_n(reset_n),
    .request(request), .confirm(confirm),
    .clear_mask(clrMask), .inputData(inputData),
    .dataOut(doB), .valid(vB), .busy(busyB),
    .done(doneB), .err(errB), .timeout(toB)
  );

  function automatic exp_t actA();
    return {busyA, doneA, errA, toA, 1'b0, vA, 7'b0, doA};
  endfunction

  function automatic exp_t actB();
    return {busyB, doneB, errB, toB, vB, doB};
  endfunction

  task automatic cmp(input string nm, input exp_t got, input exp_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s edge %0d got %h expected %h", nm, edgeN, got, want);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      armed[i] = 1'b0;
      vm[i] = '0;
      for (int k = 0; k < 4; k++) mem[i][k] = '0;
    end
  endtask

  task automatic modelEdge(input int i, input bit req, input bit conf,
                           input logic [3:0] clr, input logic [8:0] d,
                           output exp_t e);
    bit dn = 0;
    bit er = 0;
    bit tm = 0;
    int wr = -1;
    int ch = int'(d[1:0]);
    logic [27:0] dout = '0;
    if (!armed[i]) begin
      if (req) begin
        if (ch >= chN[i]) er = 1;
        else begin
          armed[i] = 1; hch[i] = ch; hpay[i] = d[8:2];
          dl[i] = edgeN + toN[i];
        end
      end
    end else if (conf) begin
      armed[i] = 0;
      if (vm[i][hch[i]] && owN[i] == 0) er = 1;
      else begin
        mem[i][hch[i]] = hpay[i]; wr = hch[i]; dn = 1;
      end
    end else if (req) begin
      if (ch >= chN[i]) begin
        er = 1; armed[i] = 0;
      end else begin
        hch[i] = ch; hpay[i] = d[8:2]; dl[i] = edgeN + toN[i];
      end
    end else if (edgeN == dl[i]) begin
      tm = 1; armed[i] = 0;
    end
    vm[i] = vm[i] & ~clr;
    if (i == 0) vm[i][3] = 1'b0;
    if (wr >= 0) vm[i][wr] = 1'b1;
    for (int k = 0; k < chN[i]; k++) dout[k*7 +: 7] = mem[i][k];
    e = {armed[i], dn, er, tm, vm[i], dout};
  endtask

  task automatic step(input bit req, input bit conf,
                      input logic [3:0] clr, input logic [8:0] d);
    exp_t e;
    @(negedge clock);
    request = req; confirm = conf; clrMask = clr; inputData = d;
    edgeN++;
    modelEdge(0, req, conf, clr, d, e);
    qA.push_back(e);
    modelEdge(1, req, conf, clr, d, e);
    qB.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 4'b0, 9'h0);
  endtask

  function automatic logic [8:0] wd(input logic [6:0] p, input int ch);
    return {p, 2'(ch)};
  endfunction

  task automatic midReset();
    @(negedge clock);
    request = 0; confirm = 0; clrMask = '0; inputData = '0;
    @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    cmp("async rst A", actA(), '0);
    cmp("async rst B", actB(), '0);
    modelReset();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // monitor: pops one expectation per DUT per stepped edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (qA.size() > 0) begin
        e = qA.pop_front();
        cmp("instA", actA(), e);
      end
      if (qB.size() > 0) begin
        e = qB.pop_front();
        cmp("instB", actB(), e);
      end
    end
  end

  initial begin
    int r;
    modelReset();
    #3;
    cmp("reset A", actA(), '0);
    cmp("reset B", actB(), '0);
    @(negedge clock);
    reset_n = 1'b1;

    step(1, 0, 4'b0, wd(7'b1010110, 1));
    step(0, 1, 4'b0, 9'h0);
    idle(1);

    step(1, 0, 4'b0, wd(7'h55, 2));
    step(0, 1, 4'b0, 9'h0);
    step(1, 0, 4'b0, wd(7'h2A, 2));
    step(0, 1, 4'b0, 9'h0);
    idle(1);

    step(1, 0, 4'b0, wd(7'h11, 0));
    idle(7);
    step(1, 0, 4'b0, wd(7'h22, 0));
    idle(2);
    step(0, 1, 4'b0, 9'h0);
    step(1, 0, 4'b0, wd(7'h33, 0));
    idle(4);
    step(0, 1, 4'b0, 9'h0);

    step(1, 0, 4'b0, wd(7'h44, 3));
    step(0, 1, 4'b0, 9'h0);
    step(1, 0, 4'b0, wd(7'h0F, 1));
    step(1, 1, 4'b0, wd(7'h70, 0));
    idle(1);

    step(0, 0, 4'b0100, 9'h0);
    step(1, 0, 4'b0, wd(7'h66, 2));
    step(0, 1, 4'b0100, 9'h0);
    step(0, 0, 4'b0100, 9'h0);
    idle(1);

    step(1, 0, 4'b0, wd(7'h5A, 1));
    midReset();
    step(0, 1, 4'b0, 9'h0);
    idle(2);

    for (int n = 0; n < 500; n++) begin
      r = $urandom;
      step((r % 3) == 0, ((r >> 2) % 3) == 0,
           ((r >> 4) % 8) == 0 ? 4'($urandom) : 4'b0,
           9'($urandom));
    end
    idle(8);
    repeat (3) @(posedge clock);
    #2;
    if (qA.size() != 0 || qB.size() != 0) begin
      errors++;
      $display("FAIL drain left %0d/%0d required 0", qA.size(), qB.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_channel_capture_controller.md
# multi_channel_capture_controller

Parametrised request/confirm capture unit that latches a tagged input word and, on confirmation, commits its payload into one of `CH` output registers selected by the word's channel field. It generalises the two-register P/Q capture path to N channels and adds per-channel valid flags, overwrite protection, a confirm timeout and selective clear. It sits between the operator input stage (switches/keypad) and the downstream consumers of the captured values.

## Interface
- `DATA_W`, default 7: payload width per channel.
- `CH`, default 4: number of channels, 2..16.
- `SEL_W`, default `$clog2(CH)`: channel-select field width.
- `TIMEOUT`, default 15: cycles allowed between request and confirm, ≥1.
- `OVERWRITE`, default 0: 1 allows a commit into a valid channel; 0 rejects it.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `request`  in  1  latch `inputData` and arm.
- `confirm`  in  1  commit the held word.
- `clear_mask`  in  CH  per-channel clear of the valid flag.
- `inputData`  in  DATA_W+SEL_W  `[DATA_W+SEL_W-1:SEL_W]` payload, `[SEL_W-1:0]` channel.
- `dataOut`  out  CH*DATA_W  channel k at `[k*DATA_W +: DATA_W]`.
- `valid`  out  CH  channel holds committed data.
- `busy`  out  1  high in ARMED.
- `done`  out  1  one-cycle pulse after a successful commit.
- `err`  out  1  one-cycle pulse on rejected request/commit.
- `timeout`  out  1  one-cycle pulse when ARMED expires.

## Operation
- States: IDLE, ARMED. Reset: IDLE, all `dataOut`, `valid`, `busy`, `done`, `err`, `timeout`, holding register and timer = 0.
- IDLE, `request`=1: if channel field ≥ `CH`, pulse `err`, stay IDLE; else latch `inputData` into holding register, timer ← 0, go ARMED. `confirm` in IDLE is ignored.
- ARMED, `confirm`=1: if `valid[ch]`=1 and `OVERWRITE`=0, pulse `err`, no write; else write payload to channel `ch`, set `valid[ch]`, pulse `done`. Either way go IDLE.
- ARMED, `request`=1 without `confirm`: re-latch (same channel-range check; out-of-range → `err`, return IDLE), restart timer.
- ARMED, neither: timer increments; when timer reaches `TIMEOUT-1` and no confirm this cycle, pulse `timeout`, go IDLE, nothing written.
- `request` and `confirm` together: IDLE → request handled; ARMED → confirm handled, request ignored.
- `clear_mask[k]`=1 clears `valid[k]` only; `dataOut` retains its value. A commit to channel k in the same cycle wins (`valid[k]` ends 1).
- `busy` = (state == ARMED), registered.

## Timing
- Request sampled at edge t → `busy` high after t.
- Confirm sampled at edge t → `dataOut`, `valid` updated and `done` high in the cycle after t; `busy` low in that same cycle. Commit latency 1 edge.
- `done`/`err`/`timeout` are registered, exactly one cycle wide, mutually exclusive.
- Timeout: request at edge t, no confirm → `timeout` high after edge t+`TIMEOUT`; confirm accepted up to and including edge t+`TIMEOUT`.
- `reset_n` low at any point (including mid-ARMED) clears everything immediately; no pulse emitted on exit from reset.

## Structure
- Shared package `capture_pkg`: state typedef (`CAP_IDLE`, `CAP_ARMED`), default parameter constants.
- Sub-module `capture_register` (parametrised `DATA_W`, enable, async active-low reset), instantiated `CH` times via generate; the FSM, timer and valid vector live in the top.

## Test plan
- Reset, request `inputData`=8'b1010110_1 (CH=2, SEL_W=1), confirm next cycle → channel 1 = 7'b1010110, `valid`=2'b10, `done` one cycle.
- CH=4, commit ch2 = 7'h55, then request ch2 = 7'h2A + confirm with `OVERWRITE`=0 → `err` pulse, ch2 stays 7'h55; with `OVERWRITE`=1 → ch2 = 7'h2A, `done`.
- Request, no confirm, `TIMEOUT`=15 → `timeout` after edge t+15, `busy` falls, no `valid` change; confirm at edge t+15 in a rerun → commit succeeds.
- CH=3: request with channel field 3 → `err`, stays IDLE; request+confirm together in ARMED → held word committed, new word discarded.
- `clear_mask`=4'b0100 with a commit to ch2 same cycle → `valid[2]`=1; clear alone → `valid[2]`=0, `dataOut` unchanged.
- Assert `reset_n` low mid-ARMED → all outputs 0 asynchronously; after release a confirm alone writes nothing.
